// File: rtl/car_light_seq.sv
// Tail-light sequencer: synchronizes switches and the blink clock, then drives
// sequential turn, hazard and brake patterns on six lamps.
module car_light_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LAMPS       = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             blink_clk,
    input  logic             left_sw,
    input  logic             right_sw,
    input  logic             hazard_sw,
    input  logic             brake_sw,
    output logic [LAMPS-1:0] left_lamp,
    output logic [LAMPS-1:0] right_lamp,
    output logic [1:0]       mode
);

    localparam int unsigned N_IN      = 5;
    localparam int unsigned FILL_W    = 3;
    localparam int unsigned FILL_DONE = SYNC_STAGES + 1;

    if (LAMPS != 3) begin : g_bad_lamps
        $error("car_light_seq: LAMPS must be 3");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("car_light_seq: SYNC_STAGES must be 2..4");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_e;

    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
    logic [N_IN-1:0]                  sync_c;
    logic                             blink_prev;
    logic [FILL_W-1:0]                fill_q;
    logic                             armed_c;
    logic                             tick_c;

    mode_e             mode_q, mode_d, req_c;
    logic [1:0]        step_q, step_d;
    logic [LAMPS-1:0]  left_d, right_d;

    logic s_blink, s_left, s_right, s_hazard, s_brake;

    // Input synchronizer chains, one per switch plus the blink clock
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {brake_sw, hazard_sw, right_sw, left_sw, blink_clk};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_c   = sync_q[SYNC_STAGES-1];
    assign s_blink  = sync_c[0];
    assign s_left   = sync_c[1];
    assign s_right  = sync_c[2];
    assign s_hazard = sync_c[3];
    assign s_brake  = sync_c[4];

    // Edge register plus a fill counter so reset-time levels never look like an edge
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            blink_prev <= 1'b0;
            fill_q     <= '0;
        end else begin
            blink_prev <= s_blink;
            if (!armed_c) begin
                fill_q <= fill_q + FILL_W'(1);
            end
        end
    end

    assign armed_c = (fill_q == FILL_W'(FILL_DONE));
    assign tick_c  = s_blink & ~blink_prev & armed_c;

    function automatic logic [LAMPS-1:0] turn_pat(input logic [1:0] s);
        case (s)
            2'd0:    turn_pat = LAMPS'(3'b000);
            2'd1:    turn_pat = LAMPS'(3'b001);
            2'd2:    turn_pat = LAMPS'(3'b011);
            default: turn_pat = LAMPS'(3'b111);
        endcase
    endfunction

    // Mode/step state register with registered lamp outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= IDLE;
            step_q     <= 2'd0;
            left_lamp  <= '0;
            right_lamp <= '0;
        end else begin
            mode_q     <= mode_d;
            step_q     <= step_d;
            left_lamp  <= left_d;
            right_lamp <= right_d;
        end
    end

    // Priority request, next mode/step and next lamp values
    always_comb begin
        mode_d  = mode_q;
        step_d  = step_q;
        left_d  = '0;
        right_d = '0;

        if (s_hazard || (s_left && s_right)) begin
            req_c = HAZARD;
        end else if (s_left) begin
            req_c = LEFT;
        end else if (s_right) begin
            req_c = RIGHT;
        end else begin
            req_c = IDLE;
        end

        if (req_c != mode_q) begin
            mode_d = req_c;
            step_d = 2'd0;
        end else if (tick_c) begin
            case (mode_q)
                LEFT, RIGHT: step_d = step_q + 2'd1;
                HAZARD:      step_d = {1'b0, ~step_q[0]};
                default:     step_d = 2'd0;
            endcase
        end

        case (mode_d)
            LEFT:    left_d  = turn_pat(step_d);
            RIGHT:   right_d = turn_pat(step_d);
            HAZARD: begin
                left_d  = {LAMPS{step_d[0]}};
                right_d = {LAMPS{step_d[0]}};
            end
            default: ;
        endcase

        // Brake lights any side not busy with a turn; hazard wins outright
        if (s_brake && mode_d != HAZARD) begin
            if (mode_d != LEFT) begin
                left_d = '1;
            end
            if (mode_d != RIGHT) begin
                right_d = '1;
            end
        end
    end

    assign mode = mode_q;

endmodule

// File: doc/car_light_seq.md
Name: car_light_seq

Overview:
Tail-light sequencer that consumes the slow blink clock from the clock divider and drives six tail lamps: three left, three right. It implements sequential turn signals, hazard flashing and brake override. The block runs entirely on the fast system clock. The divided clock is treated as data: it is synchronized, then edge-detected into a one-cycle blink tick. Outputs go directly to the board LED pins.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages in every input synchronizer (legal 2..4)
LAMPS, 3, lamps per side (fixed at 3; any other value is illegal and must trigger an elaboration error)

Ports:
clk_in  input  1  system clock
rst_n  input  1  asynchronous active-low reset
blink_clk  input  1  divided clock from the clock divider (50% duty, much slower than clk_in)
left_sw  input  1  left turn request, level, asynchronous
right_sw  input  1  right turn request, level, asynchronous
hazard_sw  input  1  hazard request, level, asynchronous
brake_sw  input  1  brake pedal, level, asynchronous
left_lamp  output  3  left lamps; bit0 = innermost
right_lamp  output  3  right lamps; bit0 = innermost
mode  output  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD

Behaviour:
- Reset: all synchronizer flops, edge register and step counter are cleared; mode=IDLE; left_lamp=000; right_lamp=000.
- Synchronization: each of the 5 inputs passes through its own SYNC_STAGES-flop chain; all logic uses only the synchronized values.
- Tick generation:
  - tick = sync_blink & ~blink_prev, where blink_prev is sync_blink delayed by one clk_in cycle.
  - tick is high for exactly one cycle per rising edge of blink_clk.
  - Falling edges of blink_clk have no effect.
- Requested mode, evaluated every cycle from the synchronized switches:
  - hazard_sw=1, or left_sw and right_sw both 1 -> HAZARD
  - else left_sw -> LEFT
  - else right_sw -> RIGHT
  - else IDLE
- Mode change:
  - When the requested mode differs from the current mode, mode is updated on the next clk_in edge, independent of tick.
  - On that same edge, step resets to 0 and both turn/hazard lamp patterns return to their step-0 values.
  - Input-to-mode latency: SYNC_STAGES+1 clk_in edges.
- Step counter: 2 bits. It advances by 1 on tick only while mode is LEFT, RIGHT or HAZARD, and wraps 3->0 in turn modes. It is held at 0 in IDLE.
- Turn pattern for the active side, indexed by step: 0 -> 000, 1 -> 001, 2 -> 011, 3 -> 111, then back to 000.
- HAZARD:
  - step bit0 toggles on each tick; step 0 -> both sides 000, step 1 -> both sides 111.
  - In HAZARD, step only takes values 0 and 1.
- Brake (synchronized brake_sw=1):
  - Any side not currently running a turn or hazard pattern is forced to 111.
  - In LEFT, right_lamp=111 and left_lamp keeps sequencing; RIGHT is symmetric.
  - In HAZARD, brake is ignored.
  - Brake has no effect on step or mode.
- Outputs are registered. A tick that arrives while the mode is changing is consumed by the mode change, so the new mode starts at step 0.
- Simultaneous switch changes are resolved entirely by the priority order above.
- Reset mid-sequence: lamps are cleared immediately (asynchronously). After rst_n deasserts, the first rising edge of blink_clk produces a tick only once the synchronizers have filled; stale high levels present at reset produce no tick.

Test Plan:
- Reset during LEFT at step 2: assert rst_n=0 -> lamps 000/000 and mode=0 immediately. Release with left_sw=1 -> mode=1 after SYNC_STAGES+1 edges, left_lamp=000.
- left_sw=1, 5 blink rising edges -> left_lamp sequence 001,011,111,000,001; right_lamp=000 throughout.
- right_sw=1 plus brake_sw=1 -> left_lamp=111 constant; right_lamp steps 001,011,111,000.
- hazard_sw=1 (or left_sw=right_sw=1), 4 ticks -> both sides 111,000,111,000; mode=3. Assert brake -> no change.
- Switch LEFT to RIGHT at step 3 -> next cycle mode=2, left_lamp=000, right_lamp=000; first tick gives right_lamp=001.
- IDLE with blink_clk toggling and brake_sw pulsed 0->1->0 -> lamps 000, then 111/111, then 000; step stays 0 and no tick has any visible effect.
